tlvds_rx_monitor: RTL and testbench

Receive-side block for a true-LVDS (TLVDS) pin pair. It converts the differential input to a single-ended level through a `TLVDS_IBUF` primitive, then synchronises and glitch-filters that level. It measures the high and low run lengths of the incoming square wave and flags link loss when the line stops toggling. It sits at the board edge opposite a `TLVDS_OBUF` transmitter and feeds status logic or LEDs in the top level.

---
 rtl/tlvds_rx_monitor.sv | 142 ++++++++++++++
 tb/tb_tlvds_rx_monitor.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlvds_rx_monitor.sv
// TLVDS receive monitor: differential input buffer, two-flop synchroniser, glitch filter,
// high/low run-length measurement and link-activity detection.

module tlvds_rx_monitor #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned TIMEOUT    = 2**25 + 2**24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tlvds_p,
  input  logic             tlvds_n,
  output logic             rx_level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             len_valid,
  output logic             link_ok
);

  localparam int unsigned      MisW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [MisW-1:0]  MisLast    = MisW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  logic             w_raw;
  logic             r_s1;
  logic             r_s2;
  logic [MisW-1:0]  r_mis_cnt;
  logic [MisW-1:0]  w_mis_cnt_nxt;
  logic             r_rx_level;
  logic             w_mismatch;
  logic             w_toggle;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_run_cnt_nxt;
  logic             r_seen_edge;
  logic             r_rise;
  logic             r_fall;
  logic             r_len_valid;
  logic             w_len_valid_nxt;
  logic             r_link_ok;
  logic             w_link_ok_nxt;
  logic [CNT_W-1:0] r_high_len;
  logic [CNT_W-1:0] r_low_len;

  TLVDS_IBUF u_ibuf (
    .I  (tlvds_p),
    .IB (tlvds_n),
    .O  (w_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // A level change is accepted on the FILTER_LEN-th consecutive mismatching sample.
  always_comb begin
    w_mismatch    = r_s2 ^ r_rx_level;
    w_toggle      = w_mismatch && (r_mis_cnt == MisLast);
    w_mis_cnt_nxt = '0;
    if (w_mismatch && !w_toggle) begin
      w_mis_cnt_nxt = r_mis_cnt + MisW'(1);
    end
  end

  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if (w_toggle) begin
      w_run_cnt_nxt = CNT_W'(1);
    end else if (r_run_cnt != CntMax) begin
      w_run_cnt_nxt = r_run_cnt + CNT_W'(1);
    end

    // The run before the first edge began at reset, so it is not a genuine measurement.
    w_len_valid_nxt = w_toggle && r_seen_edge;

    w_link_ok_nxt = r_link_ok;
    if (w_len_valid_nxt) begin
      w_link_ok_nxt = 1'b1;
    end else if (w_run_cnt_nxt == TimeoutVal) begin
      w_link_ok_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis_cnt   <= '0;
      r_rx_level  <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_run_cnt   <= '0;
      r_seen_edge <= 1'b0;
      r_high_len  <= '0;
      r_low_len   <= '0;
      r_len_valid <= 1'b0;
      r_link_ok   <= 1'b0;
    end else begin
      r_mis_cnt   <= w_mis_cnt_nxt;
      r_rx_level  <= r_rx_level ^ w_toggle;
      r_rise      <= w_toggle & ~r_rx_level;
      r_fall      <= w_toggle & r_rx_level;
      r_run_cnt   <= w_run_cnt_nxt;
      r_len_valid <= w_len_valid_nxt;
      r_link_ok   <= w_link_ok_nxt;
      if (w_toggle) begin
        r_seen_edge <= 1'b1;
        if (r_rx_level) begin
          r_high_len <= r_run_cnt;
        end else begin
          r_low_len <= r_run_cnt;
        end
      end
    end
  end

  assign rx_level   = r_rx_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign high_len   = r_high_len;
  assign low_len    = r_low_len;
  assign len_valid  = r_len_valid;
  assign link_ok    = r_link_ok;

endmodule

`ifndef SYNTHESIS
// Behavioural stand-in for the vendor primitive; synthesis binds the real TLVDS_IBUF.
module TLVDS_IBUF (
  input  logic I,
  input  logic IB,
  output logic O
);
  assign O = I & ~IB;
endmodule
`endif

// File: tb/tb_tlvds_rx_monitor.sv
// Randomised bench for tlvds_rx_monitor against a timestamp-based reference model,
// plus directed filter, timeout, saturation and reset scenarios.

module tb_tlvds_rx_monitor;

  localparam int unsigned FL  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned TO  = 200;
  localparam int unsigned SAT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tlvds_p = 1'b0;
  logic          tlvds_n = 1'b1;
  logic          p1 = 1'b0;
  logic          n1 = 1'b1;
  logic          rx_level, rise_pulse, fall_pulse, len_valid, link_ok;
  logic [CW-1:0] high_len, low_len;
  logic          rx1, rise1, fall1, valid1, link1;
  logic [CW-1:0] high1, low1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tlvds_rx_monitor #(.FILTER_LEN(FL), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tlvds_p    (tlvds_p),
    .tlvds_n    (tlvds_n),
    .rx_level   (rx_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .high_len   (high_len),
    .low_len    (low_len),
    .len_valid  (len_valid),
    .link_ok    (link_ok)
  );

  tlvds_rx_monitor #(.FILTER_LEN(1), .CNT_W(CW), .TIMEOUT(TO)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tlvds_p    (p1),
    .tlvds_n    (n1),
    .rx_level   (rx1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .high_len   (high1),
    .low_len    (low1),
    .len_valid  (valid1),
    .link_ok    (link1)
  );

  // Reference model: the pin sampled at edge t reaches the filter two edges later; a level is
  // accepted once the last FL filter inputs all disagree with the current level. Run lengths
  // come from edge timestamps.
  bit          m_q[0:FL];
  bit          m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_valid = 1'b0, m_link = 1'b0;
  bit          m_seen = 1'b0;
  int unsigned m_high = 0, m_low = 0, m_cyc = 0, m_anchor = 0;

  initial begin
    for (int i = 0; i <= FL; i++) m_q[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i <= FL; i++) m_q[i] = 1'b0;
        m_lvl = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_link = 0; m_seen = 0;
        m_high = 0; m_low = 0; m_cyc = 0; m_anchor = 0;
      end else begin
        bit          acc;
        int unsigned run_prev, run_now;
        acc = 1'b1;
        for (int i = 0; i < FL; i++) if (m_q[i] == m_lvl) acc = 1'b0;
        run_prev = (m_cyc - m_anchor > SAT) ? SAT : m_cyc - m_anchor;
        m_cyc++;
        m_rise  = acc && !m_lvl;
        m_fall  = acc && m_lvl;
        m_valid = acc && m_seen;
        if (acc) begin
          if (m_lvl) m_high = run_prev;
          else       m_low  = run_prev;
          m_anchor = m_cyc - 1;
          m_lvl    = ~m_lvl;
          m_seen   = 1'b1;
        end
        run_now = (m_cyc - m_anchor > SAT) ? SAT : m_cyc - m_anchor;
        if (m_valid) m_link = 1'b1;
        else if (run_now == TO) m_link = 1'b0;
        for (int i = 0; i < FL; i++) m_q[i] = m_q[i+1];
        m_q[FL] = tlvds_p;
      end
    end
  end

  task automatic step(input bit p);
    tlvds_p = p;
    tlvds_n = ~p;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2*CW+4:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) step(i[0]);
    obs = {rx_level, rise_pulse, fall_pulse, len_valid, link_ok, high_len, low_len};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h want 0", obs);
    end
    tlvds_p = 1'b0;
    tlvds_n = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      n_tests++;
      if ({rx_level, rise_pulse, fall_pulse} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_release: rx/rise/fall=%b want 000", {rx_level, rise_pulse, fall_pulse});
      end
    end
  endtask

  task automatic test_glitch();
    int k;
    for (int i = 0; i < 11; i++) begin
      step(i < 3);
      n_tests++;
      if (rx_level !== 1'b0 || rise_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_reject: rx=%b rise=%b want 0 0", rx_level, rise_pulse);
      end
    end
    k = 0;
    while (k < 20 && rx_level !== 1'b1) begin
      step(1'b1);
      k++;
    end
    n_tests++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL filter_latency: got %0d cycles want 6", k);
    end
    n_tests++;
    if (rise_pulse !== 1'b1 || len_valid !== 1'b0 || low_len !== CW'(m_low)) begin
      n_fail++;
      $display("FAIL first_edge: rise=%b valid=%b low_len=%0d want 1 0 %0d",
               rise_pulse, len_valid, low_len, m_low);
    end
    step(1'b1);
    n_tests++;
    if (rise_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_single: rise=%b want 0", rise_pulse);
    end
  endtask

  task automatic test_steady();
    int nv = 0;
    for (int per = 0; per < 5; per++) begin
      for (int c = 0; c < 80; c++) begin
        step(c >= 30);
        n_tests++;
        if ({rx_level, rise_pulse, fall_pulse, len_valid, link_ok} !==
            {m_lvl, m_rise, m_fall, m_valid, m_link}) begin
          n_fail++;
          $display("FAIL steady_flags: got %b want %b",
                   {rx_level, rise_pulse, fall_pulse, len_valid, link_ok},
                   {m_lvl, m_rise, m_fall, m_valid, m_link});
        end
        if (len_valid === 1'b1) begin
          nv++;
          n_tests++;
          if (rise_pulse === 1'b1 && low_len !== CW'(30)) begin
            n_fail++;
            $display("FAIL steady_low: low_len=%0d want 30", low_len);
          end else if (fall_pulse === 1'b1 && nv > 1 && high_len !== CW'(50)) begin
            n_fail++;
            $display("FAIL steady_high: high_len=%0d want 50", high_len);
          end else if (fall_pulse === 1'b1 && nv == 1 && high_len !== CW'(m_high)) begin
            n_fail++;
            $display("FAIL steady_first_high: high_len=%0d want %0d", high_len, m_high);
          end
        end
        if (nv > 0) begin
          n_tests++;
          if (link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL steady_link: link_ok=%b want 1", link_ok);
          end
        end
      end
    end
    n_tests++;
    if (nv != 10) begin
      n_fail++;
      $display("FAIL steady_count: len_valid pulses=%0d want 10", nv);
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b1;
    int len;
    for (int r = 0; r < 60; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        step(lvl);
        n_tests++;
        if ({rx_level, rise_pulse, fall_pulse, len_valid, link_ok, high_len, low_len} !==
            {m_lvl, m_rise, m_fall, m_valid, m_link, CW'(m_high), CW'(m_low)}) begin
          n_fail++;
          $display("FAIL random: rx/rise/fall/valid/link=%b high=%0d low=%0d want %b %0d %0d",
                   {rx_level, rise_pulse, fall_pulse, len_valid, link_ok}, high_len, low_len,
                   {m_lvl, m_rise, m_fall, m_valid, m_link}, m_high, m_low);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit cur;
    int k, drop;
    cur = tlvds_p;
    for (int i = 0; i < 20; i++) step(cur);
    k = 0;
    step(~cur);
    while (k < 20 && rise_pulse !== 1'b1 && fall_pulse !== 1'b1) begin
      step(~cur);
      k++;
    end
    n_tests++;
    if (k >= 20 || link_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge: edge_wait=%0d link_ok=%b want edge and 1", k, link_ok);
    end
    drop = -1;
    for (int n = 1; n <= 300; n++) begin
      step(~cur);
      if (drop < 0 && link_ok === 1'b0) drop = n;
    end
    n_tests++;
    if (drop != int'(TO) - 1) begin
      n_fail++;
      $display("FAIL timeout_drop: link_ok fell after %0d cycles want %0d", drop, TO - 1);
    end
    k = 0;
    step(cur);
    while (k < 20 && len_valid !== 1'b1) begin
      step(cur);
      k++;
    end
    n_tests++;
    if (k >= 20 || link_ok !== 1'b1 ||
        (cur ? low_len : high_len) !== CW'(SAT)) begin
      n_fail++;
      $display("FAIL saturate: wait=%0d link_ok=%b len=%0d want valid 1 %0d",
               k, link_ok, cur ? low_len : high_len, SAT);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [2*CW+4:0] obs;
    k = 0;
    while (k < 20 && rx_level !== 1'b1) begin
      step(1'b1);
      k++;
    end
    for (int i = 0; i < 10; i++) step(1'b1);
    rst_n = 1'b0;
    #1;
    obs = {rx_level, rise_pulse, fall_pulse, len_valid, link_ok, high_len, low_len};
    n_tests++;
    if (obs !== '0 || {rx1, link1} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrun_reset: outputs=%h want 0", obs);
    end
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;
    k = 0;
    while (k < 20 && rise_pulse !== 1'b1) begin
      step(1'b1);
      k++;
    end
    n_tests++;
    if (k >= 20 || len_valid !== 1'b0 || low_len !== CW'(m_low)) begin
      n_fail++;
      $display("FAIL midrun_first: wait=%0d valid=%b low_len=%0d want edge 0 %0d",
               k, len_valid, low_len, m_low);
    end
    for (int i = 0; i < 20; i++) step(1'b1);
    k = 0;
    step(1'b0);
    while (k < 20 && fall_pulse !== 1'b1) begin
      step(1'b0);
      k++;
    end
    n_tests++;
    if (k >= 20 || len_valid !== 1'b1 || high_len !== CW'(m_high) || link_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_second: wait=%0d valid=%b high_len=%0d link=%b want edge 1 %0d 1",
               k, len_valid, high_len, link_ok, m_high);
    end
  endtask

  task automatic test_filter1();
    int first = -1, highs = 0, rises = 0, falls = 0, both = 0, v_at_rise = -1, v_at_fall = -1;
    int hl = -1, lnk = -1, low_zero = -1;
    p1 = 1'b1;
    n1 = 1'b0;
    step(1'b0);
    p1 = 1'b0;
    n1 = 1'b1;
    for (int k = 2; k <= 10; k++) begin
      if (rx1 === 1'b1) highs++;
      if (first < 0 && rx1 === 1'b1) first = k - 1;
      if (rise1 === 1'b1) begin
        rises++;
        v_at_rise = int'(valid1);
        low_zero = int'(low1 == '0);
      end
      if (fall1 === 1'b1) begin
        falls++;
        v_at_fall = int'(valid1);
        hl = int'(high1);
        lnk = int'(link1);
      end
      if (rise1 === 1'b1 && fall1 === 1'b1) both++;
      step(1'b0);
    end
    n_tests++;
    if (first != 3 || highs != 1) begin
      n_fail++;
      $display("FAIL f1_latency: first high at %0d for %0d cycles want 3 for 1", first, highs);
    end
    n_tests++;
    if (rises != 1 || falls != 1 || both != 0) begin
      n_fail++;
      $display("FAIL f1_pulses: rise=%0d fall=%0d both=%0d want 1 1 0", rises, falls, both);
    end
    n_tests++;
    if (v_at_rise != 0 || low_zero != 0 || v_at_fall != 1 || hl != 1 || lnk != 1) begin
      n_fail++;
      $display("FAIL f1_capture: valid_rise=%0d low_is0=%0d valid_fall=%0d high=%0d link=%0d want 0 0 1 1 1",
               v_at_rise, low_zero, v_at_fall, hl, lnk);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_steady();
    test_random();
    test_timeout();
    test_reset_mid();
    test_filter1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
